// File: rtl/pll_lock_supervisor_if.sv
// PLL supervisor signal bundle: lock/relock requests in, PLL and system resets plus status out.
// The supervisor takes the slave view; the PLL/CSR side takes the master view.
interface pll_lock_supervisor_if;
  logic       pll_locked;    // PLL lock, asynchronous to refclk
  logic       force_relock;  // refclk-synchronous relock request
  logic       pll_rst;       // active-high reset to the PLL
  logic       sys_rst_n;     // active-low reset for PLL-clocked logic
  logic       lock_ok;       // high only while running locked
  logic       lol_pulse;     // one-cycle loss-of-lock pulse
  logic       fault;         // retries exhausted
  logic [3:0] retry_cnt;     // retries used in the current sequence

  modport master (
    output pll_locked, force_relock,
    input  pll_rst, sys_rst_n, lock_ok, lol_pulse, fault, retry_cnt
  );

  modport slave (
    input  pll_locked, force_relock,
    output pll_rst, sys_rst_n, lock_ok, lol_pulse, fault, retry_cnt
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor on the free-running reference clock.
// Pulses the PLL reset, waits for a stable synchronised lock, retries on timeout up to
// MAX_RETRY times, then parks in FAULT. Releases sys_rst_n only while running locked.
// All outputs are registered and decoded from the next state, so they change on the
// same edge as the state register.
module pll_lock_supervisor #(
  parameter int RST_PULSE    = 4,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_STABLE  = 1000,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 17
) (
  input  logic                 refclk,
  input  logic                 rst_n,
  pll_lock_supervisor_if.slave bus
);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] C_RST_LAST     = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE      = CNT_W'(1);
  localparam logic [3:0]       C_MAX_RETRY    = 4'(MAX_RETRY);

  // Synchroniser and state
  logic             r_sync1;
  logic             r_locked_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_retry;

  // Registered outputs
  logic             r_pll_rst;
  logic             r_sys_rst_n;
  logic             r_lock_ok;
  logic             r_lol_pulse;
  logic             r_fault;

  // Next-state values
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       w_retry_nxt;
  logic             w_lol_nxt;
  logic             w_force;

  // A relock request is honoured everywhere except while a PLL reset pulse is in flight.
  assign w_force = bus.force_relock && (r_state != ST_RESET_PLL);

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_locked_s <= 1'b0;
    end else begin
      r_sync1    <= bus.pll_locked;
      r_locked_s <= r_sync1;
    end
  end

  // State, shared counter and retry counter registers.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RESET_PLL;
      r_cnt   <= '0;
      r_retry <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_retry <= w_retry_nxt;
    end
  end

  // Next-state, counter and loss-of-lock decode; relock requests override everything.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;
    w_lol_nxt   = (r_state == ST_RUN) && !r_locked_s;
    if (w_force) begin
      w_state_nxt = ST_RESET_PLL;
      w_cnt_nxt   = '0;
      w_retry_nxt = 4'd0;
    end else begin
      case (r_state)
        ST_RESET_PLL: begin
          if (r_cnt == C_RST_LAST) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + C_CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (r_locked_s) begin
            w_state_nxt = ST_STABLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_TIMEOUT_LAST) begin
            w_cnt_nxt = '0;
            if (r_retry == C_MAX_RETRY) begin
              w_state_nxt = ST_FAULT;
            end else begin
              w_state_nxt = ST_RESET_PLL;
              w_retry_nxt = r_retry + 4'd1;
            end
          end else begin
            w_cnt_nxt = r_cnt + C_CNT_ONE;
          end
        end
        ST_STABLE: begin
          if (!r_locked_s) begin
            // Lock glitched: restart the timeout, keep the retry budget as is.
            w_state_nxt = ST_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_STABLE_LAST) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + C_CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!r_locked_s) begin
            // Lost lock after a good run: start a fresh attempt sequence.
            w_state_nxt = ST_RESET_PLL;
            w_cnt_nxt   = '0;
            w_retry_nxt = 4'd0;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_FAULT: begin
          w_state_nxt = ST_FAULT;
          w_cnt_nxt   = '0;
        end
        default: begin
          w_state_nxt = ST_RESET_PLL;
          w_cnt_nxt   = '0;
          w_retry_nxt = 4'd0;
        end
      endcase
    end
  end

  // Outputs registered from the next state so they line up with the state register.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_lock_ok   <= 1'b0;
      r_lol_pulse <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_pll_rst   <= (w_state_nxt == ST_RESET_PLL) || (w_state_nxt == ST_FAULT);
      r_sys_rst_n <= (w_state_nxt == ST_RUN);
      r_lock_ok   <= (w_state_nxt == ST_RUN);
      r_lol_pulse <= w_lol_nxt;
      r_fault     <= (w_state_nxt == ST_FAULT);
    end
  end

  assign bus.pll_rst   = r_pll_rst;
  assign bus.sys_rst_n = r_sys_rst_n;
  assign bus.lock_ok   = r_lock_ok;
  assign bus.lol_pulse = r_lol_pulse;
  assign bus.fault     = r_fault;
  assign bus.retry_cnt = r_retry;

endmodule
